// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule definitions: sizes, controller state type and
// the GF(2^8) helpers (S-box, round constant) used by the round block.
package aes_pkg;

  localparam int NR    = 10;
  localparam int KEY_W = 128;
  localparam int RK_AW = 4;

  typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] aa;
    logic [7:0] p;
    aa = a;
    p  = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (product of x^2..x^128), then the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] p;
    logic [7:0] r;
    p = x;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]}
             ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    logic [7:0] r;
    case (i)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/aes_key_sched_ctrl_if.sv
// Load handshake and round-key read port between the cipher datapath
// (master) and the key-schedule controller (slave).
interface aes_key_sched_ctrl_if;
  import aes_pkg::*;

  logic [KEY_W-1:0] key_in;
  logic             key_load;
  logic             key_ready;
  logic             busy;
  logic             keys_vld;
  logic [RK_AW-1:0] rk_addr;
  logic [KEY_W-1:0] rk_data;

  modport master (
    output key_in, key_load, rk_addr,
    input  key_ready, busy, keys_vld, rk_data
  );

  modport slave (
    input  key_in, key_load, rk_addr,
    output key_ready, busy, keys_vld, rk_data
  );

endinterface

// File: rtl/Key_Generate.sv
// Single AES-128 key-expansion round: registers kin/rc, so kout is the next
// round key one cycle after the inputs are presented.
module Key_Generate
  import aes_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [KEY_W-1:0] kin,
  input  logic [3:0]       rc,
  output logic [KEY_W-1:0] kout
);

  logic [KEY_W-1:0] k_reg;
  logic [3:0]       rc_reg;
  logic [31:0]      rot_w;
  logic [31:0]      sub_w;
  logic [31:0]      temp_w;
  logic [31:0]      w4, w5, w6, w7;

  always_ff @(posedge clk) begin
    if (!rst) begin
      k_reg  <= '0;
      rc_reg <= '0;
    end else begin
      k_reg  <= kin;
      rc_reg <= rc;
    end
  end

  assign rot_w = {k_reg[23:0], k_reg[31:24]};

  for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
    assign sub_w[gi*8 +: 8] = sbox(rot_w[gi*8 +: 8]);
  end

  assign temp_w = sub_w ^ {rcon(rc_reg), 24'h000000};
  assign w4     = k_reg[127:96] ^ temp_w;
  assign w5     = w4 ^ k_reg[95:64];
  assign w6     = w5 ^ k_reg[63:32];
  assign w7     = w6 ^ k_reg[31:0];
  assign kout   = {w4, w5, w6, w7};

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// AES-128 key-schedule sequencer: drives Key_Generate through rounds 1..NR and
// holds all round keys in a clearable flop store. AES_KEY_ZEROIZE_EN adds zeroize.
module aes_key_sched_ctrl
  import aes_pkg::*;
#(
  parameter int NR    = 10,
  parameter int KEY_W = 128
) (
  input  logic clk,
  input  logic rst,
`ifdef AES_KEY_ZEROIZE_EN
  input  logic zeroize,
`endif
  aes_key_sched_ctrl_if.slave kif
);

  if (NR != 10 || KEY_W != 128) begin : g_bad_cfg
    $error("aes_key_sched_ctrl supports AES-128 only (NR=10, KEY_W=128)");
  end

  localparam logic [3:0] NR_L = 4'(NR);

  state_t           state_reg;
  logic [3:0]       rnd_reg;
  logic             key_ready_reg;
  logic             busy_reg;
  logic             keys_vld_reg;
  logic [KEY_W-1:0] rk_data_reg;
  logic [KEY_W-1:0] store_reg [0:NR];

  logic             accept;
  logic             clr;
  logic [KEY_W-1:0] kg_kin;
  logic [3:0]       kg_rc;
  logic [KEY_W-1:0] kg_kout;

`ifdef AES_KEY_ZEROIZE_EN
  assign clr = !rst || zeroize;
`else
  assign clr = !rst;
`endif

  assign accept = kif.key_load && key_ready_reg;

  // Round-key feedback goes through Key_Generate's input register, not a comb loop.
  assign kg_kin = accept ? kif.key_in : kg_kout;
  assign kg_rc  = accept ? 4'd1
                : (state_reg == EXPAND && rnd_reg < NR_L) ? rnd_reg + 4'd1
                : 4'd0;

  Key_Generate u_key_generate (
    .clk  (clk),
    .rst  (rst),
    .kin  (kg_kin),
    .rc   (kg_rc),
    .kout (kg_kout)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      state_reg     <= IDLE;
      rnd_reg       <= '0;
      key_ready_reg <= 1'b1;
      busy_reg      <= 1'b0;
      keys_vld_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (accept) begin
            state_reg     <= EXPAND;
            rnd_reg       <= 4'd1;
            key_ready_reg <= 1'b0;
            busy_reg      <= 1'b1;
            keys_vld_reg  <= 1'b0;
          end
        end
        EXPAND: begin
          if (rnd_reg == NR_L) begin
            state_reg     <= DONE;
            rnd_reg       <= '0;
            key_ready_reg <= 1'b1;
            busy_reg      <= 1'b0;
            keys_vld_reg  <= 1'b1;
          end else begin
            rnd_reg <= rnd_reg + 4'd1;
          end
        end
        default: begin
          state_reg     <= IDLE;
          rnd_reg       <= '0;
          key_ready_reg <= 1'b1;
          busy_reg      <= 1'b0;
          keys_vld_reg  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i <= NR; i++) store_reg[i] <= '0;
    end else if (accept) begin
      store_reg[0] <= kif.key_in;
    end else if (state_reg == EXPAND) begin
      store_reg[rnd_reg] <= kg_kout;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      rk_data_reg <= '0;
    end else if (kif.rk_addr <= NR_L) begin
      rk_data_reg <= store_reg[kif.rk_addr];
    end else begin
      rk_data_reg <= '0;
    end
  end

  assign kif.key_ready = key_ready_reg;
  assign kif.busy      = busy_reg;
  assign kif.keys_vld  = keys_vld_reg;
  assign kif.rk_data   = rk_data_reg;

endmodule
